// File: rtl/shiftreg_pkg.sv
// Shared types and width helpers for the 74HC165 chain reader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: state_t  - read sequencer states
//           div_cnt_w - width of the per-phase divider counter
//           bit_cnt_w - width of the sampled-bit counter
package shiftreg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    SHIFT_LO,
    SHIFT_HI,
    DONE
  } state_t;

  // Must hold the value CLK_DIV itself, hence the +1.
  function automatic int div_cnt_w(input int clk_div);
    return (clk_div < 1) ? 1 : $clog2(clk_div + 1);
  endfunction

  // Must hold N_BITS itself so the "all bits taken" compare never wraps.
  function automatic int bit_cnt_w(input int n_bits);
    return (n_bits < 1) ? 1 : $clog2(n_bits + 1);
  endfunction

endpackage

// File: rtl/shiftreg_in_if.sv
// Bus between the control logic / 74HC165 chain and the shiftreg_in reader.
// Latency: n/a (wiring only).
// Backpressure: i_Enable is only honoured while o_Ready is high.
// Ports: i_Enable (read request), o_Ready (idle), o_Data/o_Valid (word + strobe),
//        o_SH_LD/o_CLK (to 165 SH/LD and CLK), i_QH (serial data from last 165).
interface shiftreg_in_if #(
  parameter int N_BITS = 8
) ();

  logic              i_Enable;
  logic              o_Ready;
  logic [N_BITS-1:0] o_Data;
  logic              o_Valid;
  logic              o_SH_LD;
  logic              o_CLK;
  logic              i_QH;

  // slave: the reader itself
  modport slave (
    input  i_Enable, i_QH,
    output o_Ready, o_Data, o_Valid, o_SH_LD, o_CLK
  );

  // master: control logic plus the board-side shift register chain
  modport master (
    output i_Enable, i_QH,
    input  o_Ready, o_Data, o_Valid, o_SH_LD, o_CLK
  );

endinterface

// File: rtl/shiftreg_in_phase_timer.sv
// Phase timer: counts CLK_DIV cycles per sequencer phase, flags the last one.
// Latency: phase_done is high in the CLK_DIV-th cycle after a restart pulse.
// Backpressure: none; a restart always reloads, even mid-count.
// Ports: clk, rst (sync, active-high), restart (reload counter),
//        phase_done (one-cycle flag, last cycle of the phase).
module phase_timer
  import shiftreg_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic phase_done
);

  localparam int DW = div_cnt_w(CLK_DIV);

  logic [DW-1:0] cnt;

  // Loaded with CLK_DIV on restart; reaching 1 marks the final cycle of the
  // phase. Parks at 0 when nobody restarts it (DONE/IDLE).
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= DW'(CLK_DIV);
    end else if (cnt != '0) begin
      cnt <= cnt - DW'(1);
    end
  end

  assign phase_done = (cnt == DW'(1));

endmodule

// File: rtl/shiftreg_in.sv
// Reads a 74HC165 chain: SH/LD load pulse, divided shift clock, QH sampled MSB-first.
// Latency: o_Valid 2*CLK_DIV + 2*CLK_DIV*N_BITS + 1 cycles after the accept cycle.
// Backpressure: o_Ready low while busy; i_Enable during a read is dropped, not queued.
// Ports: i_clk, i_rst (sync, active-high) plus bus (shiftreg_in_if.slave):
//        i_Enable/o_Ready request handshake, o_Data/o_Valid result, o_SH_LD/o_CLK/i_QH to the 165s.
module shiftreg_in
  import shiftreg_pkg::*;
#(
  parameter int N_BITS  = 8,
  parameter int CLK_DIV = 2
) (
  input logic           i_clk,
  input logic           i_rst,
  shiftreg_in_if.slave  bus
);

  localparam int BW = bit_cnt_w(N_BITS);

  state_t            state;
  state_t            state_next;
  logic              timer_restart;
  logic              phase_done;
  logic              sample;
  logic [N_BITS-1:0] shreg;
  logic [BW-1:0]     bit_cnt;

  phase_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_phase_timer (
    .clk        (i_clk),
    .rst        (i_rst),
    .restart    (timer_restart),
    .phase_done (phase_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Every timed phase is entered together with a timer restart, so the
  // timer's phase_done always refers to the phase we are currently in.
  always_comb begin
    state_next    = state;
    timer_restart = 1'b0;
    sample        = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_Enable) begin
          state_next    = LOAD;
          timer_restart = 1'b1;
        end
      end
      LOAD: begin
        if (phase_done) begin
          state_next    = SETTLE;
          timer_restart = 1'b1;
        end
      end
      SETTLE: begin
        if (phase_done) begin
          state_next    = SHIFT_LO;
          timer_restart = 1'b1;
        end
      end
      SHIFT_LO: begin
        // QH is stable here; the 165 only moves on the coming CLK rise.
        if (phase_done) begin
          sample        = 1'b1;
          state_next    = SHIFT_HI;
          timer_restart = 1'b1;
        end
      end
      SHIFT_HI: begin
        if (phase_done) begin
          if (bit_cnt == BW'(N_BITS)) begin
            state_next = DONE;
          end else begin
            state_next    = SHIFT_LO;
            timer_restart = 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath and pin outputs. Outputs are decoded from state_next so the
  // registered pins line up with the state they belong to.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      bus.o_Ready <= 1'b1;
      bus.o_Valid <= 1'b0;
      bus.o_Data  <= '0;
      bus.o_SH_LD <= 1'b1;
      bus.o_CLK   <= 1'b0;
    end else begin
      if (state == IDLE) begin
        bit_cnt <= '0;
      end else if (sample) begin
        shreg   <= (shreg << 1) | N_BITS'(bus.i_QH);
        bit_cnt <= bit_cnt + BW'(1);
      end
      if (state_next == DONE) begin
        bus.o_Data <= shreg;
      end
      bus.o_Ready <= (state_next == IDLE);
      bus.o_Valid <= (state_next == DONE);
      bus.o_SH_LD <= (state_next != LOAD);
      bus.o_CLK   <= (state_next == SHIFT_HI);
    end
  end

endmodule
